// File: rtl/dlf_lock_sequencer.sv
// Acquisition/lock sequencer for the ADPLL loop filter: filter reset, gear shifting, lock detect.
// Optional DLF_SIGN_QUAL_EN: a small sample also needs a lead sign flip within the current qualify run.
module dlf_lock_sequencer #(
    parameter int unsigned IN_WIDTH      = 8,
    parameter int unsigned LOCK_THRESH   = 4,
    parameter int unsigned UNLOCK_THRESH = 16,
    parameter int unsigned RST_CYCLES    = 4,
    parameter int unsigned DWELL_CNT     = 32,
    parameter int unsigned LOCK_CNT      = 64,
    parameter int unsigned UNLOCK_CNT    = 8,
    parameter int unsigned TIMEOUT       = 4096
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic [IN_WIDTH-1:0] master_in,
    input  logic                lead,
    output logic                filt_rstn,
    output logic [1:0]          gear,
    output logic                locked,
    output logic                busy,
    output logic                timeout_flag,
    output logic                lock_lost
);

    localparam int unsigned RW   = $clog2(RST_CYCLES) + 1;
    localparam int unsigned QMAX = (LOCK_CNT > DWELL_CNT) ? LOCK_CNT : DWELL_CNT;
    localparam int unsigned QW   = $clog2(QMAX) + 1;
    localparam int unsigned TW   = $clog2(TIMEOUT) + 1;
    localparam int unsigned UW   = $clog2(UNLOCK_CNT) + 1;
    localparam logic [IN_WIDTH-1:0] LOCK_T   = IN_WIDTH'(LOCK_THRESH);
    localparam logic [IN_WIDTH-1:0] UNLOCK_T = IN_WIDTH'(UNLOCK_THRESH);

    typedef enum logic [1:0] {S_IDLE, S_FRST, S_ACQ, S_LOCKED} state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   rcnt_q, rcnt_d, rcnt_inc;
    logic [QW-1:0]   qcnt_q, qcnt_d, qcnt_inc;
    logic [TW-1:0]   tcnt_q, tcnt_d, tcnt_inc;
    logic [UW-1:0]   ucnt_q, ucnt_d, ucnt_inc;
    logic [1:0]      gear_q, gear_d;
    logic            filt_rstn_q, filt_rstn_d;
    logic            locked_q, locked_d;
    logic            busy_q, busy_d;
    logic            tflag_q, tflag_d;
    logic            llost_q, llost_d;
    logic            mag_small_c, large_c, small_c;

    assign mag_small_c = (master_in <= LOCK_T);
    assign large_c     = (master_in > UNLOCK_T);

`ifdef DLF_SIGN_QUAL_EN
    // Sign history: previous lead, and whether the current qualify run has seen a flip.
    logic lead_q, flip_seen_q;

    assign small_c = mag_small_c && (flip_seen_q || (lead != lead_q));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            lead_q      <= 1'b0;
            flip_seen_q <= 1'b0;
        end else begin
            lead_q      <= lead;
            flip_seen_q <= start && (state_q == S_ACQ) && small_c;
        end
    end
`else
    logic unused_lead;

    assign unused_lead = lead;
    assign small_c     = mag_small_c;
`endif

    // Saturating increments so no counter can wrap.
    assign rcnt_inc = (&rcnt_q) ? rcnt_q : rcnt_q + RW'(1);
    assign qcnt_inc = (&qcnt_q) ? qcnt_q : qcnt_q + QW'(1);
    assign tcnt_inc = (&tcnt_q) ? tcnt_q : tcnt_q + TW'(1);
    assign ucnt_inc = (&ucnt_q) ? ucnt_q : ucnt_q + UW'(1);

    always_comb begin
        state_d = state_q;
        rcnt_d  = '0;
        qcnt_d  = '0;
        tcnt_d  = '0;
        ucnt_d  = '0;
        gear_d  = gear_q;
        tflag_d = tflag_q;
        llost_d = llost_q;

        case (state_q)
            S_IDLE: begin
                gear_d = 2'd0;
                if (start) begin
                    state_d = S_FRST;
                    tflag_d = 1'b0;
                    llost_d = 1'b0;
                end
            end
            S_FRST: begin
                gear_d = 2'd0;
                rcnt_d = rcnt_inc;
                if (rcnt_inc == RW'(RST_CYCLES)) begin
                    state_d = S_ACQ;
                end
            end
            S_ACQ: begin
                tcnt_d = tcnt_inc;
                qcnt_d = small_c ? qcnt_inc : '0;
                // Lock beats timeout; timeout beats a gear step on the same edge.
                if (gear_q == 2'd3 && small_c && qcnt_inc == QW'(LOCK_CNT)) begin
                    state_d = S_LOCKED;
                end else if (tcnt_inc == TW'(TIMEOUT)) begin
                    state_d = S_FRST;
                    tflag_d = 1'b1;
                    gear_d  = 2'd0;
                end else if (gear_q != 2'd3 && small_c && qcnt_inc == QW'(DWELL_CNT)) begin
                    gear_d = gear_q + 2'd1;
                    qcnt_d = '0;
                end
            end
            S_LOCKED: begin
                gear_d = 2'd3;
                ucnt_d = large_c ? ucnt_inc : '0;
                if (large_c && ucnt_inc == UW'(UNLOCK_CNT)) begin
                    state_d = S_FRST;
                    llost_d = 1'b1;
                    gear_d  = 2'd0;
                    ucnt_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                gear_d  = 2'd0;
            end
        endcase

        if (!start) begin
            state_d = S_IDLE;
            gear_d  = 2'd0;
            rcnt_d  = '0;
            qcnt_d  = '0;
            tcnt_d  = '0;
            ucnt_d  = '0;
        end

        filt_rstn_d = (state_d == S_ACQ) || (state_d == S_LOCKED);
        locked_d    = (state_d == S_LOCKED);
        busy_d      = (state_d == S_FRST) || (state_d == S_ACQ);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            rcnt_q      <= '0;
            qcnt_q      <= '0;
            tcnt_q      <= '0;
            ucnt_q      <= '0;
            gear_q      <= 2'd0;
            filt_rstn_q <= 1'b0;
            locked_q    <= 1'b0;
            busy_q      <= 1'b0;
            tflag_q     <= 1'b0;
            llost_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rcnt_q      <= rcnt_d;
            qcnt_q      <= qcnt_d;
            tcnt_q      <= tcnt_d;
            ucnt_q      <= ucnt_d;
            gear_q      <= gear_d;
            filt_rstn_q <= filt_rstn_d;
            locked_q    <= locked_d;
            busy_q      <= busy_d;
            tflag_q     <= tflag_d;
            llost_q     <= llost_d;
        end
    end

    assign filt_rstn    = filt_rstn_q;
    assign gear         = gear_q;
    assign locked       = locked_q;
    assign busy         = busy_q;
    assign timeout_flag = tflag_q;
    assign lock_lost    = llost_q;

endmodule

// File: tb/tb_dlf_lock_sequencer.sv
// Directed bench for dlf_lock_sequencer: a cycle model checked every negedge plus literal timeline pins.
module tb_dlf_lock_sequencer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       lead = 1'b0;
    logic [7:0] master_in = 8'd0;
    logic       filt_rstn, locked, busy, timeout_flag, lock_lost;
    logic [1:0] gear;

    bit lead_tog = 1'b1;
    bit chk_en = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dlf_lock_sequencer dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .master_in    (master_in),
        .lead         (lead),
        .filt_rstn    (filt_rstn),
        .gear         (gear),
        .locked       (locked),
        .busy         (busy),
        .timeout_flag (timeout_flag),
        .lock_lost    (lock_lost)
    );

    // Model phases: 0 idle, 1 filter reset, 2 acquiring, 3 locked.
    int m_ph = 0, m_rc = 0, m_q = 0, m_t = 0, m_u = 0, m_g = 0;
    bit m_tf = 1'b0, m_ll = 1'b0, m_prev = 1'b0, m_seen = 1'b0;

    always @(posedge clk) begin : model
        int ph, rc, q, t, u, g;
        bit tf, ll, seen, sm, flip;
        ph = m_ph; rc = m_rc; q = m_q; t = m_t; u = m_u; g = m_g;
        tf = m_tf; ll = m_ll; seen = m_seen;
        if (!rstn) begin
            ph = 0; rc = 0; q = 0; t = 0; u = 0; g = 0; tf = 0; ll = 0; seen = 0;
        end else if (!start) begin
            ph = 0; rc = 0; q = 0; t = 0; u = 0; g = 0; seen = 0;
        end else begin
            case (ph)
                0: begin ph = 1; rc = 0; tf = 0; ll = 0; end
                1: begin
                    rc = rc + 1; seen = 0; g = 0;
                    if (rc == 4) begin ph = 2; rc = 0; q = 0; t = 0; end
                end
                2: begin
                    t = t + 1;
                    flip = (lead != m_prev);
                    sm = (master_in <= 8'd4);
`ifdef DLF_SIGN_QUAL_EN
                    sm = sm && (seen || flip);
`endif
                    seen = sm;
                    q = sm ? q + 1 : 0;
                    if (g == 3 && q == 64) begin ph = 3; u = 0; end
                    else if (t == 4096) begin ph = 1; tf = 1; g = 0; rc = 0; end
                    else if (g < 3 && q == 32) begin g = g + 1; q = 0; end
                end
                default: begin
                    u = (master_in > 8'd16) ? u + 1 : 0;
                    if (u == 8) begin ph = 1; ll = 1; g = 0; rc = 0; u = 0; end
                end
            endcase
        end
        m_ph <= ph; m_rc <= rc; m_q <= q; m_t <= t; m_u <= u; m_g <= g;
        m_tf <= tf; m_ll <= ll; m_seen <= seen;
        m_prev <= rstn ? lead : 1'b0;
    end

    task automatic mcmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL model %s: dut=%0d model=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            mcmp("filt_rstn", 32'(filt_rstn), 32'(m_ph >= 2));
            mcmp("gear", 32'(gear), 32'(m_g));
            mcmp("locked", 32'(locked), 32'(m_ph == 3));
            mcmp("busy", 32'(busy), 32'(m_ph == 1 || m_ph == 2));
            mcmp("timeout_flag", 32'(timeout_flag), 32'(m_tf));
            mcmp("lock_lost", 32'(lock_lost), 32'(m_ll));
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        vectors++;
        if (act !== 32'(exp)) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock; new inputs are applied 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
        if (lead_tog) lead = ~lead;
    endtask

    initial begin
        tick();
        tick();
        chk_en = 1'b1;
        chk("rst_filt_rstn", 32'(filt_rstn), 0);
        chk("rst_gear", 32'(gear), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_flags", 32'({timeout_flag, lock_lost}), 0);

        // Clean lock: 4 reset cycles, gear every 32, lock at 164.
        rstn = 1'b1; start = 1'b1; master_in = 8'd2;
        tick();
        chk("frst_entry_busy", 32'(busy), 1);
        for (int i = 1; i <= 164; i++) begin
            tick();
            if (i == 3)   chk("frst_len_low", 32'(filt_rstn), 0);
            if (i == 4)   chk("frst_len_high", 32'(filt_rstn), 1);
            if (i == 35)  chk("gear0_hold", 32'(gear), 0);
            if (i == 36)  chk("gear1_step", 32'(gear), 1);
            if (i == 68)  chk("gear2_step", 32'(gear), 2);
            if (i == 99)  chk("gear2_hold", 32'(gear), 2);
            if (i == 100) chk("gear3_step", 32'(gear), 3);
            if (i == 163) chk("lock_not_yet", 32'(locked), 0);
            if (i == 164) chk("lock_at_164", 32'(locked), 1);
        end

        // Loss of lock: 7 large, 1 small, 8 large.
        master_in = 8'd20;
        for (int i = 1; i <= 7; i++) tick();
        chk("lock_hold_burst1", 32'(locked), 1);
        master_in = 8'd3;
        tick();
        master_in = 8'd20;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 7) chk("lock_hold_burst2", 32'(locked), 1);
            if (i == 8) begin
                chk("lock_fall", 32'(locked), 0);
                chk("lock_lost_set", 32'(lock_lost), 1);
                chk("unlock_to_frst", 32'(busy && !filt_rstn), 1);
            end
        end
        master_in = 8'd2;
        for (int i = 1; i <= 164; i++) begin
            tick();
            if (i == 163) chk("relock_not_yet", 32'(locked), 0);
            if (i == 164) chk("relock_at_164", 32'(locked), 1);
        end
        chk("lock_lost_sticky", 32'(lock_lost), 1);

        // Stop, then dwell restart in gear 1.
        start = 1'b0;
        tick();
        chk("idle_gear", 32'(gear), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_lock_lost_held", 32'(lock_lost), 1);
        start = 1'b1;
        tick();
        chk("restart_clears_lost", 32'(lock_lost), 0);
        for (int i = 1; i <= 36; i++) tick();
        chk("dwell_gear1", 32'(gear), 1);
        for (int i = 1; i <= 31; i++) tick();
        master_in = 8'd9;
        tick();
        chk("dwell_bad_keeps_gear", 32'(gear), 1);
        master_in = 8'd2;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i == 31) chk("dwell_gear1_hold", 32'(gear), 1);
            if (i == 32) chk("dwell_gear2_step", 32'(gear), 2);
        end

        // Abort mid-acquisition.
        start = 1'b0;
        tick();
        chk("abort_gear", 32'(gear), 0);
        chk("abort_filt_rstn", 32'(filt_rstn), 0);
        chk("abort_busy", 32'(busy), 0);

        // Lead held constant: ignored unless sign qualification is built in.
        lead_tog = 1'b0; lead = 1'b1; start = 1'b1;
        tick();
        for (int i = 1; i <= 100; i++) tick();
`ifdef DLF_SIGN_QUAL_EN
        chk("lead_const_gear", 32'(gear), 0);
`else
        chk("lead_const_gear", 32'(gear), 3);
`endif
        start = 1'b0;
        tick();
        lead_tog = 1'b1;

        // Timeout: large error for the whole acquisition window.
        start = 1'b1; master_in = 8'd50;
        tick();
        for (int i = 1; i <= 4104; i++) begin
            tick();
            if (i == 4099) chk("tmo_not_yet", 32'({timeout_flag, filt_rstn, busy}), 3);
            if (i == 4100) begin
                chk("tmo_flag", 32'(timeout_flag), 1);
                chk("tmo_filt_rstn", 32'(filt_rstn), 0);
                chk("tmo_gear", 32'(gear), 0);
            end
            if (i == 4103) chk("tmo_frst_low", 32'(filt_rstn), 0);
            if (i == 4104) chk("tmo_retry_acq", 32'(filt_rstn), 1);
        end
        master_in = 8'd2;
        for (int i = 1; i <= 160; i++) tick();
        chk("tmo_then_lock", 32'(locked), 1);
        chk("tmo_flag_sticky", 32'(timeout_flag), 1);

        // Reset while locked, then full re-lock.
        rstn = 1'b0;
        tick();
        chk("rst_locked_outputs",
            32'({filt_rstn, gear, locked, busy, timeout_flag, lock_lost}), 0);
        rstn = 1'b1;
        tick();
        chk("rst_restart_busy", 32'(busy), 1);
        for (int i = 1; i <= 164; i++) begin
            tick();
            if (i == 163) chk("rst_relock_not_yet", 32'(locked), 0);
            if (i == 164) chk("rst_relock_164", 32'(locked), 1);
        end

        start = 1'b0;
        tick();
        tick();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
